// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DBG  = 1'b1;

   // Wide enough for read latencies up to 7 cycles.
   localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-port winner select: the port named by ptr has priority on a tie.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (ptr == PORT_CORE) begin
         if (req[0])      grant = 2'b01;
         else if (req[1]) grant = 2'b10;
      end else begin
         if (req[1])      grant = 2'b10;
         else if (req[0]) grant = 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with single outstanding access.
// Build option: DMEM_ARB_RR_EN selects round-robin ties, otherwise core port wins.
//
//   state  | meaning
//   IDLE   | waiting for a request; latch winner and its command
//   ACCESS | one-cycle memory strobe (suppressed for out-of-range address)
//   WAIT   | load in flight, down-count RD_LAT cycles, capture read data
//   DONE   | one-cycle done pulse to the winner, err if out of range
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [2*ADDR_W-1:0]   addr,
   input  logic [2*DATA_W-1:0]   wdata,
   output logic [1:0]            done,
   output logic                  err,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam logic [ADDR_W:0]      DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

   arb_state_t state_q, state_d;

   logic                 win_q;
   logic                 we_q;
   logic                 oor_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [DATA_W-1:0]    rdata_q;
   logic [LAT_CNT_W-1:0] cnt_q;

   logic [1:0]           grant;
   logic                 ptr;
   logic                 win_sel;
   logic [ADDR_W-1:0]    addr_sel;
   logic                 oor_sel;
   logic                 accept;

   assign accept = (state_q == IDLE) && (|req);

`ifdef DMEM_ARB_RR_EN
   logic ptr_q;

   // The port just granted loses the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr_q <= PORT_CORE;
      else if (accept) ptr_q <= ~win_sel;
   end

   assign ptr = ptr_q;
`else
   assign ptr = PORT_CORE;
`endif

   dmem_arb_pick u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (grant)
   );

   assign win_sel  = grant[1];
   assign addr_sel = win_sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign oor_sel  = ({1'b0, addr_sel} >= DEPTH_L);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = ACCESS;
         ACCESS:  state_d = (oor_q || we_q) ? DONE : WAIT;
         WAIT:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q   <= PORT_CORE;
         we_q    <= 1'b0;
         oor_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            win_q   <= win_sel;
            we_q    <= we[win_sel];
            oor_q   <= oor_sel;
            addr_q  <= addr_sel;
            wdata_q <= win_sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
         end
         if (state_q == ACCESS) begin
            cnt_q <= LAT_LOAD;
         end else if (state_q == WAIT) begin
            if (cnt_q == '0) rdata_q <= mem_rdata;
            else             cnt_q   <= cnt_q - 1'b1;
         end
      end
   end

   always_comb begin
      done   = 2'b00;
      err    = 1'b0;
      mem_en = 1'b0;
      mem_we = 1'b0;
      case (state_q)
         ACCESS: begin
            mem_en = !oor_q;
            mem_we = !oor_q && we_q;
         end
         DONE: begin
            done = (win_q == PORT_DBG) ? 2'b10 : 2'b01;
            err  = oor_q;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign rdata     = rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with RD_LAT=2, DEPTH=256 and a pipelined memory model.
module tb_dmem_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk;
   logic          rst_n;
   logic [1:0]    req;
   logic [1:0]    we;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] wdata;
   logic [1:0]    done;
   logic          err;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .RD_LAT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: read data valid exactly two cycles after the strobe, garbage otherwise.
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] p0, p1;
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      p0 <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hBAD0;
      p1 <= p0;
   end
   assign mem_rdata = p1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // Issue one request from a port and follow it to its done pulse.
   task automatic run_txn(input logic port, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic drop,
                          output int lat, output logic [1:0] dn, output logic e,
                          output logic [15:0] rd, output int en_cnt, output logic we1);
      req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
      req[port] = 1'b1;
      we[port]  = w;
      addr[int'(port)*16 +: 16]  = a;
      wdata[int'(port)*16 +: 16] = d;
      lat = 0; dn = 2'b00; e = 1'b0; rd = '0; en_cnt = 0; we1 = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (mem_en) en_cnt++;
         if (lat == 1) begin
            we1 = mem_we;
            if (drop) req = 2'b00;
         end
         if (done != 2'b00) begin
            dn = done;
            e  = err;
            rd = rdata;
            break;
         end
      end
      req = 2'b00;
      @(negedge clk);
   endtask

   typedef struct {
      logic        port;
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      int          lat;
      logic        e;
      logic [15:0] rd;
      int          en;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int          lat, en_cnt, pulses, cyc;
      logic [1:0]  dn;
      logic        e, we1;
      logic [15:0] rd;
      logic [1:0]  exp_g[4];

      vecs[0] = '{1'b0, 1'b1, 16'd5,      16'hA5A5, 2, 1'b0, 16'h0000, 1};
      vecs[1] = '{1'b0, 1'b0, 16'd5,      16'h0000, 4, 1'b0, 16'hA5A5, 1};
      vecs[2] = '{1'b1, 1'b1, 16'd10,     16'h1234, 2, 1'b0, 16'hA5A5, 1};
      vecs[3] = '{1'b1, 1'b0, 16'd10,     16'h0000, 4, 1'b0, 16'h1234, 1};
      vecs[4] = '{1'b0, 1'b0, 16'd300,    16'h0000, 2, 1'b1, 16'h1234, 0};
      vecs[5] = '{1'b1, 1'b1, 16'd255,    16'hBEEF, 2, 1'b0, 16'h1234, 1};
      vecs[6] = '{1'b0, 1'b1, 16'd256,    16'h0BAD, 2, 1'b1, 16'h1234, 0};
      vecs[7] = '{1'b0, 1'b0, 16'd255,    16'h0000, 4, 1'b0, 16'hBEEF, 1};
      vecs[8] = '{1'b1, 1'b0, 16'hFFFF,   16'h0000, 2, 1'b1, 16'hBEEF, 0};
      vecs[9] = '{1'b1, 1'b0, 16'd5,      16'h0000, 4, 1'b0, 16'hA5A5, 1};

`ifdef DMEM_ARB_RR_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

      req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_done",   32'(done),   32'h0);
      chk("rst_err",    32'(err),    32'h0);
      chk("rst_busy",   32'(busy),   32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_rdata",  32'(rdata),  32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0,
                 lat, dn, e, rd, en_cnt, we1);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_done", i), 32'(dn), vecs[i].port ? 32'h2 : 32'h1);
         chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].e));
         chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].rd));
         chk($sformatf("v%0d_mem_en_cnt", i), 32'(en_cnt), 32'(vecs[i].en));
         chk($sformatf("v%0d_mem_we", i), 32'(we1), 32'(vecs[i].w && !vecs[i].e));
      end

      // Reset while a load is waiting on memory.
      req = 2'b01; we = 2'b00; addr = {16'd0, 16'd5}; wdata = '0;
      @(negedge clk);
      @(negedge clk);
      chk("wait_busy_before_rst", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy",  32'(busy),  32'h0);
      chk("rst_mid_done",  32'(done),  32'h0);
      chk("rst_mid_rdata", 32'(rdata), 32'h0);
      req = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (done != 2'b00) pulses++;
      end
      chk("rst_mid_no_done", 32'(pulses), 32'h0);
      run_txn(1'b0, 1'b0, 16'd5, 16'h0, 1'b0, lat, dn, e, rd, en_cnt, we1);
      chk("post_rst_latency", 32'(lat), 32'd4);
      chk("post_rst_done",    32'(dn),  32'h1);
      chk("post_rst_rdata",   32'(rd),  32'hA5A5);

      // Both ports requesting continuously for four transactions.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req = 2'b11; we = 2'b11; addr = {16'd21, 16'd20}; wdata = {16'h2222, 16'h1111};
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (done == 2'b00 && cyc < 10);
         chk($sformatf("arb_grant%0d", k), 32'(done), 32'(exp_g[k]));
         chk($sformatf("arb_latency%0d", k), 32'(cyc), k == 0 ? 32'd2 : 32'd3);
      end
      req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("arb_mem20", 32'(mem[20]), 32'h1111);

      // Debug port drops its request during the access cycle.
      run_txn(1'b1, 1'b0, 16'd10, 16'h0, 1'b1, lat, dn, e, rd, en_cnt, we1);
      chk("drop_latency", 32'(lat), 32'd4);
      chk("drop_done",    32'(dn),  32'h2);
      chk("drop_rdata",   32'(rd),  32'h1234);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (done != 2'b00) pulses++;
      end
      chk("drop_single_pulse", 32'(pulses), 32'h0);
      chk("drop_idle",         32'(busy),   32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter ADDR_W, default 16, requester/memory address width.
REQ-003 Parameter DEPTH, default 256, number of valid data-memory words.
REQ-004 Parameter RD_LAT, default 1, memory read latency in cycles (range 1..7).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req  in  2  per-port access request; bit 0 = core load/store, bit 1 = loader/debug.
REQ-008 we  in  2  per-port write enable (1 store, 0 load), qualified by req.
REQ-009 addr  in  2*ADDR_W  packed per-port word address; port i at [i*ADDR_W +: ADDR_W].
REQ-010 wdata  in  2*DATA_W  packed per-port store data.
REQ-011 done  out  2  one-cycle per-port completion pulse.
REQ-012 err  out  1  valid with done; 1 = address out of range, access suppressed.
REQ-013 rdata  out  DATA_W  load data, valid in the cycle done is high.
REQ-014 busy  out  1  high whenever FSM is not IDLE.
REQ-015 mem_en / mem_we  out  1 each  memory access strobe and write select.
REQ-016 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and store data.
REQ-017 mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en with mem_we=0.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-019 IDLE: when any req bit is high, SHALL latch winner index, we, addr and wdata, then enter ACCESS next cycle.
REQ-020 ACCESS: SHALL drive mem_en=1 for exactly one cycle with the latched we/addr/wdata; stores go to DONE, loads to WAIT.
REQ-021 WAIT: SHALL count RD_LAT cycles, capture mem_rdata into rdata on the last count, then enter DONE.
REQ-022 DONE: SHALL pulse done[winner] for one cycle, then return to IDLE unconditionally.
REQ-023 Latency from req sampled in IDLE to done SHALL be 2 cycles for a store and 2+RD_LAT cycles for a load.
REQ-024 Requester SHALL hold req/we/addr/wdata stable until its done; deasserting req mid-access SHALL NOT abort; done still pulses.
REQ-025 Out-of-range addr (>= DEPTH) SHALL suppress mem_en, skip WAIT, and assert err with done in the cycle after ACCESS.
REQ-026 rdata SHALL hold its last captured value between loads; stores and errored accesses SHALL NOT change it.
REQ-027 mem_en, mem_we and done SHALL be 0 in all states other than those specified above.

Reset
REQ-028 rst_n low SHALL immediately force IDLE; done, err, busy, mem_en and mem_we = 0; rdata = 0; RR pointer = port 0.
REQ-029 Reset mid-access SHALL drop the in-flight operation with no done pulse; a store not yet strobed SHALL NOT reach memory.

Configuration
REQ-030 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin; the port granted last loses the next tie.
REQ-031 With DMEM_ARB_RR_EN undefined, port 0 SHALL always win ties (fixed priority), and no pointer register SHALL exist.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the FSM state enum, port index constants (PORT_CORE=0, PORT_DBG=1) and RD_LAT counter width.
REQ-033 Winner selection SHALL be a sub-module, dmem_arb_pick (req, pointer -> one-hot grant).

Verification
REQ-034 Core store addr=5 wdata=16'hA5A5 -> mem_en and mem_we high in cycle 1, done[0] in cycle 2, err=0.
REQ-035 RD_LAT=2, core load addr=5 with mem_rdata=16'hA5A5 -> done[0] in cycle 4, rdata=16'hA5A5.
REQ-036 Both req high for 4 transactions -> RR on: grants 0,1,0,1; RR off: grants 0,0,0,0 while req[0] stays high.
REQ-037 DEPTH=256, load addr=300 -> no mem_en, done and err high in cycle 2, rdata unchanged.
REQ-038 rst_n pulsed low during WAIT -> busy=0 immediately, no done pulse, next request completes normally.
REQ-039 req[1] dropped during ACCESS -> done[1] still pulses once, then FSM returns to IDLE.
